alu_seq_core: RTL and testbench

//  Parametrised sequential ALU; successor to the combinational 8-bit adder tile.

---
 rtl/alu_seq_core.sv | 238 +++++++++++++++++++++++
 tb/tb_alu_seq_core.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_core.sv
// Sequential ALU with valid/ready request/response handshakes, registered flags and an accumulator.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier for op 111.
module alu_seq_core #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             use_acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RESP = 2'b01
`ifdef ALU_SEQ_MUL_EN
    , S_MUL = 2'b10
`endif
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
  } alu_res_t;

  // Single-cycle operations; op 111 falls to the all-zero default.
  function automatic alu_res_t alu_eval(input logic [2:0]       f_op,
                                        input logic [WIDTH-1:0] f_a,
                                        input logic [WIDTH-1:0] f_b);
    alu_res_t       o;
    logic [WIDTH:0] w;
    logic [SHW-1:0] amt;
    o   = '0;
    w   = '0;
    amt = f_b[SHW-1:0];
    case (f_op)
      OP_ADD: begin
        w     = {1'b0, f_a} + {1'b0, f_b};
        o.res = w[WIDTH-1:0];
        o.c   = w[WIDTH];
        o.v   = (f_a[WIDTH-1] == f_b[WIDTH-1]) && (o.res[WIDTH-1] != f_a[WIDTH-1]);
      end
      OP_SUB: begin
        w     = {1'b0, f_a} - {1'b0, f_b};
        o.res = w[WIDTH-1:0];
        o.c   = w[WIDTH];
        o.v   = (f_a[WIDTH-1] != f_b[WIDTH-1]) && (o.res[WIDTH-1] != f_a[WIDTH-1]);
      end
      OP_AND: o.res = f_a & f_b;
      OP_OR:  o.res = f_a | f_b;
      OP_XOR: o.res = f_a ^ f_b;
      OP_SHL: begin
        w     = {1'b0, f_a} << amt;
        o.res = w[WIDTH-1:0];
        o.c   = w[WIDTH];
      end
      OP_SHR: begin
        w     = {f_a, 1'b0} >> amt;
        o.res = w[WIDTH:1];
        o.c   = w[0];
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_ovf;
  logic             r_zero;
  logic [WIDTH-1:0] w_opa;
  alu_res_t         w_alu;
  alu_res_t         w_nxt;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_mul_done;
  logic             w_res_ld;

  assign w_opa    = use_acc ? r_acc : a;
  assign w_alu    = alu_eval(op, w_opa, b);
  assign w_accept = in_valid && (r_state == S_IDLE);

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [SHW-1:0]     r_cnt;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod_nxt;

  assign w_is_mul   = (op == OP_MUL);
  assign w_mul_done = (r_state == S_MUL) && (r_cnt == SHW'(WIDTH - 1));
  assign w_sum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
  // Shift-add step: high half accumulates the multiplicand when the multiplier LSB is set.
  assign w_prod_nxt = r_prod[0] ? {w_sum, r_prod[WIDTH-1:1]} : {1'b0, r_prod[2*WIDTH-1:1]};

  // Multiplier operand, partial product and step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
    end else if (w_accept && w_is_mul) begin
      r_mcand <= w_opa;
      r_prod  <= {{WIDTH{1'b0}}, b};
      r_cnt   <= '0;
    end else if (r_state == S_MUL) begin
      r_prod  <= w_prod_nxt;
      r_cnt   <= r_cnt + SHW'(1);
    end else begin
      r_cnt   <= r_cnt;
    end
  end
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_done = 1'b0;
`endif

  assign w_res_ld = (w_accept && !w_is_mul) || w_mul_done;

  // Selects the value loaded into the result/flag registers.
  always_comb begin
    w_nxt = w_alu;
`ifdef ALU_SEQ_MUL_EN
    if (r_state == S_MUL) begin
      w_nxt.res = w_prod_nxt[WIDTH-1:0];
      w_nxt.c   = 1'b0;
      w_nxt.v   = |w_prod_nxt[2*WIDTH-1:WIDTH];
    end else begin
      w_nxt = w_alu;
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
          w_state_nxt = w_is_mul ? S_MUL : S_RESP;
`else
          w_state_nxt = S_RESP;
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      S_MUL: begin
        if (w_mul_done) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_MUL;
        end
      end
`endif
      S_RESP: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Result and flags load once per operation and hold through the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_res_ld) begin
      r_result <= w_nxt.res;
      r_carry  <= w_nxt.c;
      r_ovf    <= w_nxt.v;
      r_zero   <= (w_nxt.res == '0);
    end else begin
      r_result <= r_result;
    end
  end

  // Accumulator follows the result only when the response is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if ((r_state == S_RESP) && out_ready) begin
      r_acc <= r_result;
    end else begin
      r_acc <= r_acc;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_RESP);
  assign busy      = (r_state != S_IDLE);
  assign result    = r_result;
  assign carry     = r_carry;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core (WIDTH=8) with an arithmetic reference model checked every cycle.
module tb_alu_seq_core;
  localparam int W = 8;
`ifdef ALU_SEQ_MUL_EN
  localparam int MUL_EDGES = W;
`else
  localparam int MUL_EDGES = 0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic         use_acc;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         ovf;
  logic         zero;
  logic         busy;

  always #5 clk = ~clk;

  alu_seq_core #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .use_acc(use_acc), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .ovf(ovf), .zero(zero), .busy(busy)
  );

  typedef struct { int res; int c; int v; int z; } exp_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int to_signed8(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Reference arithmetic on plain integers.
  function automatic exp_t model(input int opc, input int x, input int y);
    exp_t e;
    int   s;
    int   n;
    e = '{0, 0, 0, 0};
    n = y % 8;
    case (opc)
      0: begin
        s = x + y; e.res = s % 256; e.c = (s >= 256);
        s = to_signed8(x) + to_signed8(y); e.v = (s > 127) || (s < -128);
      end
      1: begin
        e.res = (x - y + 256) % 256; e.c = (x < y);
        s = to_signed8(x) - to_signed8(y); e.v = (s > 127) || (s < -128);
      end
      2: e.res = x & y;
      3: e.res = x | y;
      4: e.res = x ^ y;
      5: begin e.res = (x << n) % 256; e.c = (n == 0) ? 0 : (x >> (8 - n)) % 2; end
      6: begin e.res = x >> n; e.c = (n == 0) ? 0 : (x >> (n - 1)) % 2; end
      default: begin
`ifdef ALU_SEQ_MUL_EN
        s = x * y; e.res = s % 256; e.v = (s >= 256);
`else
        e.res = 0;
`endif
      end
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  exp_t m_exp;
  bit   m_busy;
  bit   m_outv;
  int   m_cnt;
  int   m_acc;

  // Transaction-level model: accept, count down latency, hold until consumed.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_outv = 1'b0; m_cnt = 0; m_acc = 0;
    end else if (m_outv) begin
      if (out_ready) begin m_acc = m_exp.res; m_outv = 1'b0; m_busy = 1'b0; end
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) m_outv = 1'b1;
    end else if (in_valid) begin
      m_exp  = model(int'(op), use_acc ? m_acc : int'(a), int'(b));
      m_busy = 1'b1;
      m_cnt  = (op == 3'd7) ? MUL_EDGES : 0;
      m_outv = (m_cnt == 0);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_result", int'(result), 0);
      check("rst_flags", int'({carry, ovf, zero}), 0);
    end else begin
      check("in_ready", int'(in_ready), int'(!m_busy));
      check("busy", int'(busy), int'(m_busy));
      check("out_valid", int'(out_valid), int'(m_outv));
      if (m_outv) begin
        check("result", int'(result), m_exp.res);
        check("carry", int'(carry), m_exp.c);
        check("ovf", int'(ovf), m_exp.v);
        check("zero", int'(zero), m_exp.z);
      end
    end
  end

  task automatic req(input logic [2:0] o, input bit ua, input logic [W-1:0] x,
                     input logic [W-1:0] y, input int lat_exp, output exp_t got);
    int n;
    int lat;
    in_valid = 1'b1; op = o; use_acc = ua; a = x; b = y; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("accept_timeout", n, 0);
    @(negedge clk);
    in_valid = 1'b0; a = ~x; b = ~y; op = o ^ 3'd1; use_acc = !ua;
    lat = 1;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    check("latency", lat, lat_exp);
    got.res = int'(result); got.c = int'(carry); got.v = int'(ovf); got.z = int'(zero);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  exp_t g;
  int   t_op [8] = '{6, 5, 5, 2, 3, 4, 0, 1};
  int   t_a  [8] = '{8'h81, 8'h81, 8'h5A, 8'hF0, 8'hF0, 8'hF0, 8'h7F, 3};
  int   t_b  [8] = '{9, 1, 8, 8'h3C, 8'h3C, 8'h3C, 1, 5};
  int   t_r  [8] = '{8'h40, 8'h02, 8'h5A, 8'h30, 8'hFC, 8'hCC, 8'h80, 8'hFE};
  int   t_c  [8] = '{1, 1, 0, 0, 0, 0, 0, 1};
  int   t_v  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = 3'd0; use_acc = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    req(3'd0, 1'b0, 8'd200, 8'd100, 1, g);
    check("t1_res", g.res, 44); check("t1_c", g.c, 1); check("t1_v", g.v, 0); check("t1_z", g.z, 0);

    req(3'd1, 1'b0, 8'h80, 8'h01, 1, g);
    check("t2_res", g.res, 8'h7F); check("t2_c", g.c, 0); check("t2_v", g.v, 1);
    req(3'd1, 1'b0, 8'd3, 8'd3, 1, g);
    check("t2_res0", g.res, 0); check("t2_z", g.z, 1);

    req(3'd0, 1'b0, 8'd5, 8'd3, 1, g);
    check("t3_add", g.res, 8);
    req(3'd0, 1'b1, 8'hFF, 8'd2, 1, g);
    check("t3_acc_add", g.res, 10);
    req(3'd5, 1'b1, 8'hFF, 8'd4, 1, g);
    check("t3_shl", g.res, 8'hA0); check("t3_shl_c", g.c, 0);

    for (int i = 0; i < 8; i++) begin
      req(3'(t_op[i]), 1'b0, 8'(t_a[i]), 8'(t_b[i]), 1, g);
      check($sformatf("tab%0d_res", i), g.res, t_r[i]);
      check($sformatf("tab%0d_c", i), g.c, t_c[i]);
      check($sformatf("tab%0d_v", i), g.v, t_v[i]);
    end

    // Back-pressure: response held while a new request waits.
    in_valid = 1'b1; op = 3'd0; use_acc = 1'b0; a = 8'd50; b = 8'd25;
    while (!in_ready) @(negedge clk);
    @(negedge clk);
    a = 8'd1; b = 8'd1;
    check("t4_ov", int'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_res", int'(result), 75);
      check("t4_hold_ready", int'(in_ready), 0);
      check("t4_hold_busy", int'(busy), 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t4_idle_ready", int'(in_ready), 1);
    check("t4_idle_ov", int'(out_valid), 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("t4_new_ov", int'(out_valid), 1);
    check("t4_new_res", int'(result), 2);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

`ifdef ALU_SEQ_MUL_EN
    req(3'd7, 1'b0, 8'd13, 8'd11, W + 1, g);
    check("t5_mul", g.res, 8'h8F); check("t5_mul_v", g.v, 0);
    req(3'd7, 1'b0, 8'd20, 8'd20, W + 1, g);
    check("t5_mul2", g.res, 8'h90); check("t5_mul2_v", g.v, 1);
`else
    req(3'd7, 1'b0, 8'd13, 8'd11, 1, g);
    check("t5_nomul", g.res, 0); check("t5_nomul_z", g.z, 1);
`endif

    // Reset in the middle of an operation aborts it and clears the accumulator.
    req(3'd0, 1'b0, 8'd1, 8'd1, 1, g);
    in_valid = 1'b1; op = 3'd7; a = 8'd13; b = 8'd11; use_acc = 1'b0;
    while (!in_ready) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("t6_rst_res", int'(result), 0);
    check("t6_rst_ov", int'(out_valid), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("t6_no_resp", int'(out_valid), 0);
    end
    check("t6_ready", int'(in_ready), 1);
    req(3'd0, 1'b1, 8'hFF, 8'd7, 1, g);
    check("t6_acc_add", g.res, 7);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
